// File: rtl/crypto_arbiter.sv
// Round-robin arbiter sharing one crypto accelerator between NUM_REQ requesters.
// Grants a job, waits for done/error or a watchdog expiry, then routes the response.
module crypto_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = 2,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [4*NUM_REQ-1:0]   req_op,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic                   resp_error,
  output logic                   accel_enable,
  output logic [3:0]             accel_operation,
  output logic [SEL_W-1:0]       accel_sel,
  input  logic                   accel_done,
  input  logic                   accel_error,
  output logic                   busy,
  output logic [15:0]            timeout_count
);

  typedef enum logic [1:0] {IDLE, WAIT, COOL} state_t;

  localparam logic [3:0] MAX_OP = 4'd4;

  state_t               state, state_nx;
  logic [SEL_W-1:0]     last_grant, last_grant_nx;
  logic [TO_W-1:0]      wd, wd_nx;

  logic [SEL_W-1:0]     cand, idx;
  logic                 found;
  logic [3:0]           sel_op;

  logic [NUM_REQ-1:0]   ready_nx, resp_valid_nx;
  logic                 resp_error_nx, enable_nx, busy_nx;
  logic [3:0]           op_nx;
  logic [SEL_W-1:0]     sel_nx;
  logic [15:0]          tc_nx;

  // Round-robin search starting just after the last grant.
  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    cand   = '0;
    sel_op = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = SEL_W'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (idx == SEL_W'(i)) sel_op = req_op[4*i +: 4];
    end
  end

  always_comb begin
    state_nx      = state;
    last_grant_nx = last_grant;
    wd_nx         = wd;
    ready_nx      = '0;
    resp_valid_nx = '0;
    resp_error_nx = 1'b0;
    enable_nx     = 1'b0;
    op_nx         = accel_operation;
    sel_nx        = accel_sel;
    tc_nx         = timeout_count;

    unique case (state)
      IDLE: begin
        if (found) begin
          ready_nx[idx] = 1'b1;
          last_grant_nx = idx;
          if (sel_op <= MAX_OP) begin
            enable_nx = 1'b1;
            op_nx     = sel_op;
            sel_nx    = idx;
            wd_nx     = '0;
            state_nx  = WAIT;
          end else begin
            resp_valid_nx[idx] = 1'b1;
            resp_error_nx      = 1'b1;
            state_nx           = COOL;
          end
        end
      end
      WAIT: begin
        // A completion on the expiry cycle wins over the watchdog.
        if (accel_done || accel_error) begin
          resp_valid_nx[last_grant] = 1'b1;
          resp_error_nx             = accel_error;
          state_nx                  = COOL;
        end else if (wd == TO_W'(TIMEOUT - 1)) begin
          resp_valid_nx[last_grant] = 1'b1;
          resp_error_nx             = 1'b1;
          if (timeout_count != 16'hFFFF) tc_nx = timeout_count + 16'd1;
          state_nx = COOL;
        end else begin
          wd_nx = wd + TO_W'(1);
        end
      end
      COOL:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    busy_nx = (state_nx != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      last_grant      <= SEL_W'(NUM_REQ - 1);
      wd              <= '0;
      req_ready       <= '0;
      resp_valid      <= '0;
      resp_error      <= 1'b0;
      accel_enable    <= 1'b0;
      accel_operation <= '0;
      accel_sel       <= '0;
      busy            <= 1'b0;
      timeout_count   <= '0;
    end else begin
      state           <= state_nx;
      last_grant      <= last_grant_nx;
      wd              <= wd_nx;
      req_ready       <= ready_nx;
      resp_valid      <= resp_valid_nx;
      resp_error      <= resp_error_nx;
      accel_enable    <= enable_nx;
      accel_operation <= op_nx;
      accel_sel       <= sel_nx;
      busy            <= busy_nx;
      timeout_count   <= tc_nx;
    end
  end

endmodule

// File: tb/tb_crypto_arbiter.sv
// Bench for crypto_arbiter: directed scenarios plus randomized traffic, all checked
// cycle by cycle against a transaction-level reference model.
module tb_crypto_arbiter;

  localparam int N       = 4;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_op;
  logic [3:0]  req_ready, resp_valid;
  logic        resp_error, accel_enable, accel_done, accel_error, busy;
  logic [3:0]  accel_operation;
  logic [1:0]  accel_sel;
  logic [15:0] timeout_count;

  crypto_arbiter #(.NUM_REQ(N), .SEL_W(2), .TIMEOUT(TIMEOUT), .TO_W(7)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_error(resp_error),
    .accel_enable(accel_enable), .accel_operation(accel_operation),
    .accel_sel(accel_sel), .accel_done(accel_done), .accel_error(accel_error),
    .busy(busy), .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive values for the current cycle and observed outputs of that cycle.
  logic        drv_rst, drv_done, drv_err;
  logic [3:0]  drv_rv;
  logic [15:0] drv_op;
  logic [3:0]  o_ready, o_resp, o_op;
  logic        o_err, o_en, o_busy;
  logic [1:0]  o_sel;
  logic [15:0] o_tc;
  int          cyc = 0, o_cyc = 0;

  // Reference model: who owns the accelerator, when its job started, cooldown flag.
  int          m_ptr, m_owner, m_en_cyc, m_sel, m_op, m_tc;
  bit          m_cool;
  logic [3:0]  e_ready, e_resp;
  logic        e_err, e_en, e_busy;

  function automatic void model_reset();
    m_ptr = N - 1; m_owner = -1; m_cool = 0; m_en_cyc = 0;
    m_sel = 0; m_op = 0; m_tc = 0;
    e_ready = '0; e_resp = '0; e_err = 0; e_en = 0; e_busy = 0;
  endfunction

  function automatic void model_step(input logic [3:0] rv, input logic [15:0] ops,
                                     input logic done, input logic err, input int now);
    int w;
    logic [3:0] op_w;
    e_ready = '0; e_resp = '0; e_err = 0; e_en = 0;
    if (m_cool) begin
      m_cool = 0;
    end else if (m_owner >= 0) begin
      if (done || err) begin
        e_resp = 4'(1 << m_owner); e_err = err; m_owner = -1; m_cool = 1;
      end else if (now + 1 == m_en_cyc + TIMEOUT) begin
        e_resp = 4'(1 << m_owner); e_err = 1; m_owner = -1; m_cool = 1;
        if (m_tc < 65535) m_tc++;
      end
    end else begin
      w = -1;
      for (int k = 1; k <= N; k++) begin
        int i = (m_ptr + k) % N;
        if (w < 0 && ((rv >> i) & 4'd1) != 0) w = i;
      end
      if (w >= 0) begin
        op_w    = 4'(ops >> (4 * w));
        m_ptr   = w;
        e_ready = 4'(1 << w);
        if (op_w <= 4'd4) begin
          e_en = 1; m_op = int'(op_w); m_sel = w; m_owner = w; m_en_cyc = now + 1;
        end else begin
          e_resp = 4'(1 << w); e_err = 1; m_cool = 1;
        end
      end
    end
    e_busy = (m_owner >= 0) || m_cool;
  endfunction

  // One clock: drive, observe at negedge, compare with model, advance model.
  task automatic step();
    rst = drv_rst; req_valid = drv_rv; req_op = drv_op;
    accel_done = drv_done; accel_error = drv_err;
    if (drv_rst) model_reset();
    @(negedge clk);
    o_ready = req_ready; o_resp = resp_valid; o_err = resp_error; o_en = accel_enable;
    o_op = accel_operation; o_sel = accel_sel; o_busy = busy; o_tc = timeout_count;
    o_cyc = cyc;
    check("req_ready", o_ready, e_ready);
    check("resp_valid", o_resp, e_resp);
    check("resp_error", o_err, e_err);
    check("accel_enable", o_en, e_en);
    check("busy", o_busy, e_busy);
    check("timeout_count", o_tc, m_tc);
    check("accel_sel", o_sel, m_sel);
    if (o_en) check("accel_operation", o_op, m_op);
    if (!drv_rst) model_step(drv_rv, drv_op, drv_done, drv_err, cyc);
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    drv_rst = 1; drv_rv = '0; drv_op = '0; drv_done = 0; drv_err = 0;
    step(); step();
    drv_rst = 0;
  endtask

  // Results of run_job, relative to its first cycle.
  int          t_rdy, t_en, t_resp;
  logic [3:0]  g_who, r_who, g_op;
  logic [1:0]  g_sel;
  logic        r_err;
  logic [15:0] r_tc;

  // Requesters in pend hold until accepted; accelerator completes lat cycles after
  // enable (lat < 0: never), raising error as well when both is set.
  task automatic run_job(input string tag, input logic [3:0] pend0, input logic [15:0] ops,
                         input int lat, input bit both);
    int start = cyc;
    logic [3:0] pend = pend0;
    t_rdy = -1; t_en = -1; t_resp = -1;
    for (int n = 0; n < 200 && t_resp < 0; n++) begin
      drv_rv = pend; drv_op = ops;
      drv_done = (t_en >= 0) && (lat >= 0) && (cyc == start + t_en + lat);
      drv_err  = drv_done && both;
      step();
      if (o_ready != 0 && t_rdy < 0) begin t_rdy = o_cyc - start; g_who = o_ready; end
      pend &= ~o_ready;
      if (o_en) begin t_en = o_cyc - start; g_op = o_op; g_sel = o_sel; end
      if (o_resp != 0) begin t_resp = o_cyc - start; r_who = o_resp; r_err = o_err; r_tc = o_tc; end
    end
    check({tag, "_resp_seen"}, t_resp >= 0, 1);
    drv_rv = '0; drv_done = 0; drv_err = 0;
  endtask

  int rr_exp[4] = '{0, 1, 3, 0};

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got hang, expected completion");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst = 1; req_valid = '0; req_op = '0; accel_done = 0; accel_error = 0;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Single AES job: request at cycle 0, done at cycle 12.
    run_job("aes", 4'b0001, 16'h0000, 11, 0);
    check("aes_ready_cyc", t_rdy, 1);
    check("aes_ready_who", g_who, 4'b0001);
    check("aes_en_cyc", t_en, 1);
    check("aes_op", g_op, 0);
    check("aes_resp_cyc", t_resp, 13);
    check("aes_resp_who", r_who, 4'b0001);
    check("aes_resp_err", r_err, 0);
    step(); step();
    check("aes_busy_c15", o_busy, 0);

    // Reset mid-WAIT, then requester 1 must win with no stale response.
    do_reset();
    drv_rv = 4'b0001; step();
    drv_rv = 4'b0010; step(); step(); step();
    check("rst_pre_busy", o_busy, 1);
    drv_rst = 1; step();
    check("rst_ready", o_ready, 0);
    check("rst_resp", o_resp, 0);
    check("rst_en", o_en, 0);
    check("rst_busy", o_busy, 0);
    check("rst_sel", o_sel, 0);
    drv_rst = 0;
    run_job("rst", 4'b0010, 16'h0000, 11, 0);
    check("rst_grant_who", g_who, 4'b0010);
    check("rst_grant_cyc", t_rdy, 1);
    check("rst_no_stale", t_resp > t_en, 1);

    // Round robin with requesters 0,1,3 held high.
    do_reset();
    begin
      int g = 0, last = -100, due = -1, who;
      for (int n = 0; n < 200 && g < 4; n++) begin
        drv_rv = 4'b1011; drv_op = 16'h2222; drv_done = (cyc == due); drv_err = 0;
        step();
        if (o_en) begin
          who = -1;
          for (int i = 0; i < N; i++) if (o_ready[i]) who = i;
          check("rr_grant", who, rr_exp[g]);
          check("rr_sel", o_sel, rr_exp[g]);
          if (g > 0) check("rr_spacing", (o_cyc - last) >= 14, 1);
          last = o_cyc; due = o_cyc + 11; g++;
        end
      end
      check("rr_count", g, 4);
      drv_rv = '0; drv_done = 0;
    end

    // Watchdog: accelerator never answers, then requester 2 is served.
    do_reset();
    run_job("wd", 4'b0101, 16'h0000, -1, 0);
    check("wd_latency", t_resp - t_en, TIMEOUT);
    check("wd_err", r_err, 1);
    check("wd_owner", r_who, 4'b0001);
    check("wd_tc", r_tc, 1);
    run_job("wd2", 4'b0100, 16'h0000, 11, 0);
    check("wd_next_who", g_who, 4'b0100);

    // Illegal opcode on requester 2.
    do_reset();
    run_job("ill", 4'b0100, 16'h0700, 11, 0);
    check("ill_same_cyc", t_rdy, t_resp);
    check("ill_ready_who", g_who, 4'b0100);
    check("ill_resp_who", r_who, 4'b0100);
    check("ill_err", r_err, 1);
    check("ill_no_enable", t_en, -1);

    // Simultaneous done+error, then done on the watchdog expiry cycle.
    do_reset();
    run_job("both", 4'b0001, 16'h0000, 5, 1);
    check("both_err", r_err, 1);
    run_job("edge", 4'b0010, 16'h0000, TIMEOUT - 1, 0);
    check("edge_latency", t_resp - t_en, TIMEOUT);
    check("edge_err", r_err, 0);
    check("edge_tc", r_tc, 0);

    // Randomized traffic with spurious accelerator pulses.
    do_reset();
    begin
      logic [3:0] pend = '0;
      int due = -1;
      bit due_err = 0;
      for (int n = 0; n < 2500; n++) begin
        if ($urandom_range(0, 3) == 0) pend |= 4'($urandom);
        if ($urandom_range(0, 31) == 0) pend &= ~4'($urandom);
        if ((n % 8) == 0) drv_op = 16'($urandom) & 16'h7777;
        drv_rv   = pend;
        drv_done = (cyc == due) && !due_err;
        drv_err  = (cyc == due) && due_err;
        if ($urandom_range(0, 31) == 0) drv_done = 1;
        if ($urandom_range(0, 63) == 0) drv_err = 1;
        step();
        pend &= ~o_ready;
        if (o_en) begin
          case ($urandom_range(0, 9))
            0:       due = -1;
            1, 2:    due = o_cyc + $urandom_range(TIMEOUT - 3, TIMEOUT + 3);
            default: due = o_cyc + $urandom_range(1, 20);
          endcase
          due_err = ($urandom_range(0, 4) == 0);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
